// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the raw pins, frames
// 11-bit PS/2 words, strips break sequences, tags E0-extended codes and
// holds one make code on a valid/ack slot for the game FSM.
// Optional build macro: PS2_PARITY_CHECK_EN (enables odd-parity checking).
module ps2_key_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  input  logic       ack,
  output logic       ps2_valid,
  output logic [7:0] ps2_data,
  output logic       ps2_ext,
  output logic       overrun_o,
  output logic       frame_err_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]    FILT_MAX = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    DECODE
  } state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic [7:0]    filt_cnt;
  logic          filt_clk;
  logic          filt_clk_d;
  logic          fall_pulse;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] tcnt;
  logic          ext_flag;
  logic          brk_flag;
  logic          parity_ok;
  logic          sample;

  assign sample = dat_sync[1];

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;

  // Odd parity across the data byte and the received parity bit
  always_comb begin
    parity_ok = ^{shreg, par_bit};
  end
`else
  // Parity bit is clocked past but not validated
  always_comb begin
    parity_ok = 1'b1;
  end
`endif

  // Pin synchronizers, PS/2 clock glitch filter and falling-edge pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync   <= '1;
      dat_sync   <= '1;
      filt_cnt   <= '0;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
      fall_pulse <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_i};
      dat_sync <= {dat_sync[0], ps2_dat_i};
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 8'd1;
      end
      filt_clk_d <= filt_clk;
      fall_pulse <= filt_clk_d & ~filt_clk;
    end
  end

  // Frame FSM with timeout, byte decode and the output slot/handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      tcnt        <= '0;
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      ps2_valid   <= 1'b0;
      ps2_data    <= '0;
      ps2_ext     <= 1'b0;
      overrun_o   <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      frame_err_o <= 1'b0;
      // A load in DECODE below overrides this clear when both coincide
      if (ack && ps2_valid) begin
        ps2_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (fall_pulse && !sample) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA, PARITY, STOP: begin
          if (fall_pulse) begin
            tcnt <= '0;
            case (state)
              DATA: begin
                shreg   <= {sample, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  state <= PARITY;
                end
              end
              PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                par_bit <= sample;
`endif
                state <= STOP;
              end
              default: begin
                if (sample && parity_ok) begin
                  state <= DECODE;
                end else begin
                  frame_err_o <= 1'b1;
                  state       <= IDLE;
                end
              end
            endcase
          end else if (tcnt == TO_MAX) begin
            frame_err_o <= 1'b1;
            tcnt        <= '0;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DECODE: begin
          tcnt  <= '0;
          state <= IDLE;
          if (shreg == 8'hE0) begin
            ext_flag <= 1'b1;
          end else if (shreg == 8'hF0) begin
            brk_flag <= 1'b1;
          end else begin
            if (!brk_flag) begin
              if (!ps2_valid || ack) begin
                ps2_data  <= shreg;
                ps2_ext   <= ext_flag;
                ps2_valid <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: stimulus pushes expected codes/errors,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_ps2_key_rx;

  localparam int FL = 4;
  localparam int TO = 200;
  localparam int H  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk_i = 1'b1;
  logic       ps2_dat_i = 1'b1;
  logic       ack = 1'b0;
  logic       ps2_valid;
  logic [7:0] ps2_data;
  logic       ps2_ext;
  logic       overrun_o;
  logic       frame_err_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int last_fall_cyc = 0;
  bit auto_ack = 1'b1;
  bit lat_arm = 1'b0;
  logic [8:0] code_q[$];
  int         err_q[$];

  ps2_key_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk_i(ps2_clk_i),
    .ps2_dat_i(ps2_dat_i),
    .ack(ack),
    .ps2_valid(ps2_valid),
    .ps2_data(ps2_data),
    .ps2_ext(ps2_ext),
    .overrun_o(overrun_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit flip);
    return {1'b1, (~^b) ^ flip, b, 1'b0};
  endfunction

  task automatic send_raw(input logic [10:0] f, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_dat_i = f[i];
      repeat (H / 2) @(negedge clk);
      if (glitch) begin
        ps2_clk_i = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk_i = 1'b1;
      end
      repeat (H / 2) @(negedge clk);
      ps2_clk_i = 1'b0;
      last_fall_cyc = cyc;
      if (i == 10) stop_cyc = cyc;
      repeat (H) @(negedge clk);
      ps2_clk_i = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit flip, input bit glitch);
    send_raw(mk(b, flip), 11, glitch);
    repeat (30) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, ps2_valid, 0);
    check({tag, "_data"}, ps2_data, 0);
    check({tag, "_ext"}, ps2_ext, 0);
    check({tag, "_overrun"}, overrun_o, 0);
    check({tag, "_frame_err"}, frame_err_o, 0);
  endtask

  // Consumer: one-cycle ack whenever a code is held and acking is enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ack = auto_ack && rst && ps2_valid && !ack;
    end
  end

  // Monitor: compares every presented code and error pulse against the queues
  initial begin
    logic prev_valid;
    logic prev_err;
    bit   drop_pend;
    logic [8:0] exp_code;
    int   kind;
    prev_valid = 1'b0;
    prev_err   = 1'b0;
    drop_pend  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_valid = 1'b0;
        prev_err   = 1'b0;
        drop_pend  = 1'b0;
      end else begin
        if (drop_pend) check("ack_drop", ps2_valid, 0);
        drop_pend = 1'b0;
        if (ps2_valid && !prev_valid) begin
          if (code_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_code: got 0x%0h, expected none", {ps2_ext, ps2_data});
          end else begin
            exp_code = code_q.pop_front();
            check("code", {ps2_ext, ps2_data}, exp_code);
          end
          if (lat_arm) begin
            check("latency", cyc - stop_cyc, FL + 5);
            lat_arm = 1'b0;
          end
        end
        if (ps2_valid && ack) drop_pend = 1'b1;
        if (frame_err_o) begin
          check("err_pulse_width", prev_err, 0);
          if (!prev_err) begin
            if (err_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame_err: got 1, expected 0");
            end else begin
              kind = err_q.pop_front();
              if (kind == 1) check("timeout_delay", cyc - last_fall_cyc, FL + 4 + TO);
            end
          end
        end
        prev_valid = ps2_valid;
        prev_err   = frame_err_o;
      end
    end
  end

  initial begin
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // Plain make code with latency measured from the stop-bit fall
    lat_arm = 1'b1;
    code_q.push_back({1'b0, 8'h75});
    send_byte(8'h75, 1'b0, 1'b0);

    // Extended make, then extended break that must stay silent
    code_q.push_back({1'b1, 8'h74});
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'h74, 1'b0, 1'b0);
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h74, 1'b0, 1'b0);

    // Overrun: second code arrives while the first is unacknowledged
    auto_ack = 1'b0;
    code_q.push_back({1'b0, 8'h1C});
    send_byte(8'h1C, 1'b0, 1'b0);
    send_byte(8'h1B, 1'b0, 1'b0);
    check("overrun_data_held", ps2_data, 8'h1C);
    check("overrun_valid_held", ps2_valid, 1);
    check("overrun_flag", overrun_o, 1);
    auto_ack = 1'b1;
    repeat (5) @(negedge clk);
    check("valid_after_ack", ps2_valid, 0);
    code_q.push_back({1'b0, 8'h23});
    send_byte(8'h23, 1'b0, 1'b0);
    check("overrun_sticky", overrun_o, 1);

    // Bad parity
`ifdef PS2_PARITY_CHECK_EN
    err_q.push_back(0);
`else
    code_q.push_back({1'b0, 8'h1D});
`endif
    send_byte(8'h1D, 1'b1, 1'b0);

    // Truncated frame: start + 4 data bits, then silence
    err_q.push_back(1);
    send_raw(mk(8'h6B, 1'b0), 5, 1'b0);
    repeat (TO + 60) @(negedge clk);
    code_q.push_back({1'b0, 8'h6B});
    send_byte(8'h6B, 1'b0, 1'b0);

    // Glitchy partial frame interrupted by a one-cycle reset
    send_raw(mk(8'h72, 1'b0), 4, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("midframe_reset");
    rst = 1'b1;
    repeat (20) @(negedge clk);
    code_q.push_back({1'b0, 8'h72});
    send_byte(8'h72, 1'b0, 1'b1);

    repeat (20) @(negedge clk);
    check("codes_outstanding", code_q.size(), 0);
    check("errs_outstanding", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
